// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 mux tree, one register level per tree level (latency log2(NUM_IN)); hold freezes
// every stage so nothing in flight is dropped. Optional channel auto-scan built when MUX_TREE_SCAN_EN is defined.
module mux_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 16,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan
);

  localparam int LEVELS = SEL_W;

  if (NUM_IN < 2 || (1 << SEL_W) != NUM_IN) begin : g_bad_num_in
    $error("mux_tree_pipe: NUM_IN must be a power of two and >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("mux_tree_pipe: WIDTH must be >= 1");
  end

  logic [SEL_W-1:0] eff_sel;

`ifdef MUX_TREE_SCAN_EN
  logic [SEL_W-1:0] scan_ptr;

  // Counter only moves on accepted scan samples; NUM_IN is a power of two so it wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= '0;
    end else if (!hold && mode && in_valid) begin
      scan_ptr <= scan_ptr + SEL_W'(1);
    end
  end

  assign eff_sel = mode ? scan_ptr : sel;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign eff_sel     = sel;
`endif

  genvar k;
  for (k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N = NUM_IN >> k;
    logic [WIDTH-1:0] dat [N];
    logic [SEL_W-1:0] tag;
    logic             vld;

    if (k == 1) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) dat[i] <= '0;
          tag <= '0;
          vld <= 1'b0;
        end else if (!hold) begin
          for (int i = 0; i < N; i++) begin
            dat[i] <= eff_sel[0] ? in_bus[(2*i+1)*WIDTH +: WIDTH]
                                 : in_bus[(2*i)*WIDTH +: WIDTH];
          end
          tag <= eff_sel;
          vld <= in_valid;
        end
      end
    end else begin : g_next
      // Each sample steers itself with the select it captured at entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) dat[i] <= '0;
          tag <= '0;
          vld <= 1'b0;
        end else if (!hold) begin
          for (int i = 0; i < N; i++) begin
            dat[i] <= g_lvl[k-1].tag[k-1] ? g_lvl[k-1].dat[2*i+1]
                                          : g_lvl[k-1].dat[2*i];
          end
          tag <= g_lvl[k-1].tag;
          vld <= g_lvl[k-1].vld;
        end
      end
    end
  end

  assign out       = g_lvl[LEVELS].dat[0];
  assign out_valid = g_lvl[LEVELS].vld;
  assign out_chan  = g_lvl[LEVELS].tag;

endmodule
